uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, byte capacity; power of two, minimum 2.
REQ-004 SHALL have port clk_in  input  1  system clock; the only clock.
REQ-005 SHALL have port rst_n_in  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port data_byte_in  input  8  byte to enqueue.
REQ-007 SHALL have port valid_in  input  1  data_byte_in valid this cycle.
REQ-008 SHALL have port ready_out  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port fifo_count_out  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight.
REQ-010 SHALL have port busy_out  output  1  byte in flight or FIFO non-empty.
REQ-011 SHALL have port tx_wire_out  output  1  UART TX line, idle high.

Function
REQ-012 SHALL define P = INPUT_CLOCK_FREQ / BAUD_RATE (integer division) as cycles per bit.
REQ-013 SHALL drive ready_out = (fifo_count_out < FIFO_DEPTH), decoded from registered state only; no combinational path from valid_in.
REQ-014 SHALL enqueue data_byte_in on a rising edge where valid_in && ready_out; valid_in while ready_out is low is ignored, with no drop flag.
REQ-015 SHALL pop at most one byte per cycle; simultaneous push and pop leaves fifo_count_out unchanged.
REQ-016 SHALL use a full-flag-free design: push is allowed only when count < FIFO_DEPTH, even if a pop occurs in the same cycle.
REQ-017 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-018 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx high; if fifo_count_out > 0, pop head into shift register, reset bit timer, go to START.
REQ-020 START: tx low for P cycles, then go to DATA with bit index 0.
REQ-021 DATA: tx = shift[0] for P cycles per bit; shift right and increment index; after bit 7, go to STOP.
REQ-022 STOP: tx high for P cycles, then go to IDLE.
REQ-023 SHALL make a frame 10*P cycles plus exactly 1 IDLE cycle between back-to-back frames.
REQ-024 SHALL give a latency of 2 cycles from accepting a byte into an empty, IDLE block to tx_wire_out going low.
REQ-025 SHALL make the in-flight byte immune to later pushes; shift register contents change only on a pop.
REQ-026 SHALL register tx_wire_out, with no glitches.
REQ-027 SHALL drive busy_out = (state != IDLE) || (fifo_count_out != 0).

Reset
REQ-028 SHALL, while rst_n_in is low, force tx_wire_out = 1, fifo_count_out = 0, busy_out = 0, ready_out = 0, state = IDLE, pointers and timers = 0.
REQ-029 SHALL abort a frame immediately on mid-frame reset assertion, with the line returning high asynchronously; queued bytes are discarded.
REQ-030 SHALL assert ready_out on the first clock edge after rst_n_in deasserts; no partial frame is ever resumed.

Verification (INPUT_CLOCK_FREQ=40, BAUD_RATE=10, so P=4; FIFO_DEPTH=4)
REQ-031 Single byte: push 0x55 at cycle 0 -> tx low at cycles 2-5, then data bits 1,0,1,0,1,0,1,0 of 4 cycles each, then stop high at cycles 38-41, busy_out low from cycle 42.
REQ-032 Back-to-back: push 0xA3, 0x0F in consecutive cycles -> frames decode to 0xA3 then 0x0F, second start bit begins exactly 1 cycle after first stop ends.
REQ-033 Full: push 6 bytes on consecutive cycles -> first pops, next 4 fill FIFO, 6th is refused (ready_out=0, count=4), decoded output is bytes 1-5 in order.
REQ-034 Push and pop in same cycle at count=2 -> count stays 2, order preserved.
REQ-035 Reset mid-DATA of 0xFF with 2 bytes queued -> tx_wire_out=1 immediately, count=0, no further frames; a new push of 0x81 after release transmits correctly.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Ports: clk_in/rst_n_in, data_byte_in/valid_in/ready_out push side,
//   fifo_count_out, busy_out status, tx_wire_out serial line.
module uart_tx_buffered #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [7:0]                    data_byte_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          busy_out,
  output logic                          tx_wire_out
);

  localparam int P  = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // fifo state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;

  // serializer state
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic push;
  logic pop;
  logic tick;

  assign push = valid_in && ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign tick = (timer_q == TW'(P - 1));

  // FIFO bookkeeping
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // ready is a flop so valid_in never reaches it combinationally
    ready_d = (count_d < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= data_byte_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // serializer: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // serializer: next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_q];
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // serializer: outputs, decoded from current state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    // busy is registered too so it stays aligned with the tx line
    busy_d = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign ready_out      = ready_q;
  assign fifo_count_out = count_q;
  assign busy_out       = busy_q;
  assign tx_wire_out    = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with P=4, depth 4.
// A passive line decoder records each frame's byte and start cycle.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [2:0] count;
  logic       busy;
  logic       tx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic [7:0] dec_b;
  int         dec_t0;

  uart_tx_buffered #(
    .INPUT_CLOCK_FREQ(40),
    .BAUD_RATE(10),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .data_byte_in(data),
    .valid_in(valid),
    .ready_out(ready),
    .fifo_count_out(count),
    .busy_out(busy),
    .tx_wire_out(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // line decoder: detect start, sample mid-bit
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      dec_t0 = cyc;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        dec_b[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx === 1'b1) begin
        rx_q.push_back(dec_b);
        rx_t.push_back(dec_t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rxb(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic int rxt(input int i);
    return (i < rx_t.size()) ? rx_t[i] : -1;
  endfunction

  // checks tx every cycle across one whole frame
  task automatic frame(input logic [7:0] b, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("%s_bit%0d_%0d", tag, k, j), 32'(tx), 32'(f[k]));
      end
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin
    int base;
    int lows;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(ready), 32'd1);

    // single byte, cycle-exact
    data  = 8'h55;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("t1_c0_count", 32'(count), 32'd1);
    check("t1_c0_tx", 32'(tx), 32'd1);
    @(negedge clk);
    check("t1_c1_tx", 32'(tx), 32'd1);
    check("t1_c1_busy", 32'(busy), 32'd1);
    check("t1_c1_count", 32'(count), 32'd0);
    frame(8'h55, "t1");
    check("t1_c41_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_c42_busy", 32'(busy), 32'd0);
    check("t1_c42_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    clear_rx();

    // back-to-back
    data  = 8'hA3;
    valid = 1'b1;
    @(negedge clk);
    base = cyc;
    data = 8'h0F;
    @(negedge clk);
    valid = 1'b0;
    check("t2_count", 32'(count), 32'd1);
    wait_to(base + 90);
    check("t2_nframes", 32'(rx_q.size()), 32'd2);
    check("t2_byte0", 32'(rxb(0)), 32'hA3);
    check("t2_byte1", 32'(rxb(1)), 32'h0F);
    check("t2_start0", 32'(rxt(0) - base), 32'd2);
    check("t2_gap", 32'(rxt(1) - rxt(0)), 32'd41);
    check("t2_busy", 32'(busy), 32'd0);
    clear_rx();

    // fill the FIFO, sixth byte refused
    data  = 8'h11;
    valid = 1'b1;
    @(negedge clk);
    base = cyc;
    data = 8'h22;
    @(negedge clk);
    data = 8'h33;
    @(negedge clk);
    data = 8'h44;
    @(negedge clk);
    data = 8'h55;
    @(negedge clk);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(ready), 32'd0);
    data = 8'h66;
    @(negedge clk);
    valid = 1'b0;
    check("t3_refused_count", 32'(count), 32'd4);
    check("t3_refused_ready", 32'(ready), 32'd0);
    wait_to(base + 215);
    check("t3_nframes", 32'(rx_q.size()), 32'd5);
    check("t3_byte0", 32'(rxb(0)), 32'h11);
    check("t3_byte1", 32'(rxb(1)), 32'h22);
    check("t3_byte2", 32'(rxb(2)), 32'h33);
    check("t3_byte3", 32'(rxb(3)), 32'h44);
    check("t3_byte4", 32'(rxb(4)), 32'h55);
    check("t3_busy", 32'(busy), 32'd0);
    clear_rx();

    // push and pop together at count 2
    data  = 8'hA1;
    valid = 1'b1;
    @(negedge clk);
    base = cyc;
    data = 8'hB2;
    @(negedge clk);
    data = 8'hC3;
    @(negedge clk);
    valid = 1'b0;
    check("t4_count2", 32'(count), 32'd2);
    wait_to(base + 41);
    check("t4_pre_count", 32'(count), 32'd2);
    data  = 8'hD4;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("t4_pushpop_count", 32'(count), 32'd2);
    wait_to(base + 220);
    check("t4_nframes", 32'(rx_q.size()), 32'd4);
    check("t4_byte0", 32'(rxb(0)), 32'hA1);
    check("t4_byte1", 32'(rxb(1)), 32'hB2);
    check("t4_byte2", 32'(rxb(2)), 32'hC3);
    check("t4_byte3", 32'(rxb(3)), 32'hD4);
    clear_rx();

    // reset mid-DATA with bytes queued
    data  = 8'hFF;
    valid = 1'b1;
    @(negedge clk);
    base = cyc;
    data = 8'h12;
    @(negedge clk);
    data = 8'h34;
    @(negedge clk);
    valid = 1'b0;
    check("t5_count", 32'(count), 32'd2);
    wait_to(base + 20);
    check("t5_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rel_ready", 32'(ready), 32'd1);
    check("t5_rel_count", 32'(count), 32'd0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_frames", 32'(lows), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    clear_rx();
    data  = 8'h81;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (50) @(negedge clk);
    check("t5_nframes", 32'(rx_q.size()), 32'd1);
    check("t5_byte", 32'(rxb(0)), 32'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
